// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: hex glyph table (active-high {g,f,e,d,c,b,a})
// and the all-dark active-low cathode pattern.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Entry n holds the glyph for hex digit n; listed from F down to 0.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Nibble to active-low cathode pattern {g,f,e,d,c,b,a}.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] cat
);

    assign cat = ~hex_to_seg(nib);

endmodule

// File: rtl/seg7_display_driver.sv
// Time-multiplexed N-digit common-anode seven-segment driver with frame-coherent
// loads, per-digit dp/blanking, leading-zero suppression and PWM brightness.
module seg7_display_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int BRIGHT_W    = 4,
    parameter int GUARD       = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_in,
    input  logic [4*NUM_DIGITS-1:0]   val_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank_in,
    input  logic                      lzb_in,
    input  logic [BRIGHT_W-1:0]       bright_in,
    output logic [6:0]                cat_out,
    output logic                      dp_out,
    output logic [NUM_DIGITS-1:0]     an_out,
    output logic                      frame_out
);

    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SLOT_W = $clog2(REFRESH_DIV);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0] GUARD_END = SLOT_W'(GUARD);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    typedef struct packed {
        logic [NUM_DIGITS-1:0][3:0] val;
        logic [NUM_DIGITS-1:0]      dp;
        logic [NUM_DIGITS-1:0]      blank;
        logic                       lzb;
    } disp_t;

    logic [SLOT_W-1:0]   slot_cnt;
    logic [IDX_W-1:0]    digit_idx;
    logic [BRIGHT_W-1:0] pwm_cnt;

    disp_t in_d, pend_q, disp_q;

    logic slot_wrap, boundary;
    logic [NUM_DIGITS-1:0][6:0] seg_dec;
    logic [NUM_DIGITS-1:0]      digit_dark;
    logic                       cur_dark, cur_lit;

    assign in_d      = {val_in, dp_in, blank_in, lzb_in};
    assign slot_wrap = (slot_cnt == SLOT_LAST);
    assign boundary  = slot_wrap && (digit_idx == IDX_LAST);

    // ---------------------------------------------------------------- counters
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
            pwm_cnt   <= '0;
        end else begin
            pwm_cnt  <= pwm_cnt + 1'b1;
            slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
            if (slot_wrap)
                digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
        end
    end

    // Display only changes at the frame boundary so a frame never tears; a load
    // landing on the boundary itself bypasses pending and shows immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            disp_q <= '0;
        end else begin
            if (load_in)
                pend_q <= in_d;
            if (boundary)
                disp_q <= load_in ? in_d : pend_q;
        end
    end

    // ---------------------------------------------------------------- per digit
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        seg7_hex_decode u_dec (
            .nib (disp_q.val[i]),
            .cat (seg_dec[i])
        );

        // Digit i is a leading zero when it and every digit above it are zero.
        if (i == 0) begin : g_lsd
            assign digit_dark[i] = disp_q.blank[i];
        end else begin : g_upper
            assign digit_dark[i] = disp_q.blank[i] |
                (disp_q.lzb && (disp_q.val[NUM_DIGITS-1:i] == '0));
        end
    end

    assign cur_dark = digit_dark[digit_idx];
    assign cur_lit  = (slot_cnt >= GUARD_END) && (pwm_cnt <= bright_in) && !cur_dark;

    // ---------------------------------------------------------------- outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            an_out    <= '1;
            cat_out   <= SEG_OFF;
            dp_out    <= 1'b1;
            frame_out <= 1'b0;
        end else begin
            frame_out <= boundary;
            an_out    <= cur_lit ? ~(NUM_DIGITS'(1) << digit_idx) : '1;
            cat_out   <= cur_dark ? SEG_OFF : seg_dec[digit_idx];
            dp_out    <= cur_dark | ~disp_q.dp[digit_idx];
        end
    end

endmodule

// File: tb/tb_seg7_display_driver.sv
// Bench for seg7_display_driver: directed steps plus random loads/brightness,
// checked cycle by cycle against an arithmetic model of the display timing.
module tb_seg7_display_driver;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BW = 2;
    localparam int GD = 1;
    localparam int FRAME = ND * RD;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_in;
    logic [15:0]   val_in;
    logic [3:0]    dp_in;
    logic [3:0]    blank_in;
    logic          lzb_in;
    logic [1:0]    bright_in;
    logic [6:0]    cat_out;
    logic          dp_out;
    logic [3:0]    an_out;
    logic          frame_out;

    seg7_display_driver #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BRIGHT_W    (BW),
        .GUARD       (GD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_in   (load_in),
        .val_in    (val_in),
        .dp_in     (dp_in),
        .blank_in  (blank_in),
        .lzb_in    (lzb_in),
        .bright_in (bright_in),
        .cat_out   (cat_out),
        .dp_out    (dp_out),
        .an_out    (an_out),
        .frame_out (frame_out)
    );

    always #5 clk = ~clk;

    // Active-high glyphs {g..a} for 0..F.
    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model state: cycles since reset release, pending and displayed contents.
    int          t;
    logic [15:0] pv, dv;
    logic [3:0]  pd, dd, pb, db;
    logic        pl, dl;

    int vectors = 0;
    int miscompares = 0;

    task automatic check_out(input string tag, input logic [6:0] act, input logic [6:0] exp);
        vectors++;
        assert (act === exp) else begin
            miscompares++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, act, exp);
        end
    endtask

    // One clock: predict the registered outputs from the pre-edge state, advance the model.
    task automatic tick();
        logic [3:0] e_an;
        logic [6:0] e_cat;
        logic       e_dp, e_fr, dark, lit;
        int slot, idx, pwm, hi;
        if (rst) begin
            e_an = 4'hF; e_cat = 7'h7F; e_dp = 1'b1; e_fr = 1'b0;
        end else begin
            slot = t % RD;
            idx  = (t / RD) % ND;
            pwm  = t % (1 << BW);
            hi = 0;
            for (int i = 0; i < ND; i++)
                if (dv[i*4 +: 4] != 4'h0) hi = i;
            dark  = db[idx] || (dl && idx > hi);
            lit   = (slot >= GD) && (pwm <= int'(bright_in)) && !dark;
            e_an  = lit ? ~(4'b0001 << idx) : 4'hF;
            e_cat = dark ? 7'h7F : ~glyph[dv[idx*4 +: 4]];
            e_dp  = dark ? 1'b1 : ~dd[idx];
            e_fr  = (t % FRAME) == FRAME - 1;
            if (e_fr) begin
                if (load_in) begin dv = val_in; dd = dp_in; db = blank_in; dl = lzb_in; end
                else         begin dv = pv;     dd = pd;    db = pb;       dl = pl;     end
            end
            if (load_in) begin pv = val_in; pd = dp_in; pb = blank_in; pl = lzb_in; end
        end
        @(posedge clk);
        if (rst) begin
            t = 0;
            pv = '0; pd = '0; pb = '0; pl = 1'b0;
            dv = '0; dd = '0; db = '0; dl = 1'b0;
        end else begin
            t++;
        end
        #1;
        check_out("an_out",    {3'b0, an_out},    {3'b0, e_an});
        check_out("cat_out",   cat_out,           e_cat);
        check_out("dp_out",    {6'b0, dp_out},    {6'b0, e_dp});
        check_out("frame_out", {6'b0, frame_out}, {6'b0, e_fr});
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic run_to(input int ph);
        for (int k = 0; k < 2 * FRAME && (t % FRAME) != ph; k++) tick();
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b, input logic z);
        val_in = v; dp_in = d; blank_in = b; lzb_in = z; load_in = 1'b1;
        tick();
        load_in = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load_in = 1'b0; val_in = '0; dp_in = '0; blank_in = '0;
        lzb_in = 1'b0; bright_in = 2'd3; t = 0;

        // Reset held three cycles.
        run(3);
        rst = 1'b0;

        // Basic value with a dp on digit 1; appears from the following frame.
        load(16'h12AF, 4'b0010, 4'b0000, 1'b0);
        run(40);

        // Two mid-frame loads: only the last is shown, and only from the next frame.
        run_to(5);
        load(16'h0000, 4'b0000, 4'b0000, 1'b0);
        run(3);
        load(16'h0005, 4'b0000, 4'b0000, 1'b1);
        run(36);
        load(16'h0000, 4'b0000, 4'b0000, 1'b1);
        run(36);

        // Load exactly on the frame boundary goes straight to display.
        run_to(FRAME - 1);
        load(16'hBEEF, 4'b1001, 4'b0000, 1'b0);
        run(20);

        // Minimum brightness, then everything blanked.
        bright_in = 2'd0;
        run(20);
        bright_in = 2'd3;
        load(16'h3C7D, 4'b1111, 4'b1111, 1'b0);
        run(40);

        // Random loads (including some on the boundary) and live brightness changes.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(7) == 0) bright_in = 2'($urandom);
            if ($urandom_range(9) == 0 || (t % FRAME == FRAME - 1 && $urandom_range(1) == 0)) begin
                logic [15:0] rv;
                rv = 16'($urandom);
                if ($urandom_range(2) == 0) rv = rv & (16'hFFFF >> (4 * $urandom_range(3)));
                load(rv, 4'($urandom), ($urandom_range(3) == 0) ? 4'($urandom) : 4'b0000,
                     1'($urandom));
            end else begin
                tick();
            end
        end

        // Reset in the middle of digit 2's slot; counters restart at digit 0.
        bright_in = 2'd3;
        load(16'h9876, 4'b0100, 4'b0000, 1'b0);
        run(20);
        run_to(9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
